param_processor: RTL and testbench

PARAM_PROCESSOR -- requirements
Module: param_processor

---
 rtl/param_processor.sv | 275 +++++++++++++++++++++++++++
 tb/tb_param_processor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/param_processor.sv
// Small multi-cycle accumulator-style processor: 16-entry register file, unified
// program/data memory, and a FETCH/DECODE/EXECUTE/WRITEBACK sequencer.
module param_processor #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MEM_AW   = 8,
    parameter int unsigned START_PC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              prog_we,
    input  logic [MEM_AW-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_wdata,
    input  logic [MEM_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic [MEM_AW-1:0] pc_out,
    output logic [4:0]        psr_out
);

    localparam int unsigned DEPTH = 2 ** MEM_AW;
    localparam int unsigned NREG  = 16;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_LOAD   = 4'd1;
    localparam logic [3:0] OP_STORE  = 4'd2;
    localparam logic [3:0] OP_BRANCH = 4'd3;
    localparam logic [3:0] OP_XOR    = 4'd4;
    localparam logic [3:0] OP_ADD    = 4'd5;
    localparam logic [3:0] OP_ROTATE = 4'd6;
    localparam logic [3:0] OP_SHIFT  = 4'd7;
    localparam logic [3:0] OP_HALT   = 4'd8;
    localparam logic [3:0] OP_COMPL  = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [MEM_AW-1:0]   pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic [3:0]          opcode_q, opcode_d;
    logic [3:0]          cc_q, cc_d;
    logic [11:0]         src_q, src_d;
    logic [11:0]         dest_q, dest_d;
    logic [4:0]          psr_q, psr_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                halted_q, halted_d;
    logic [DATA_W-1:0]   rf_q [NREG];
    logic [DATA_W-1:0]   rf_d [NREG];
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                mem_we_c;
    logic [MEM_AW-1:0]   mem_waddr_c;
    logic [DATA_W-1:0]   mem_wdata_c;

    logic [DATA_W-1:0]   rs_c, rd_c, imm_c, operand_c;
    logic [DATA_W:0]     sum_c;
    logic [DATA_W-1:0]   shift_res_c, rot_res_c, result_c;
    logic                shift_c_c, carry_c, branch_c, flags_c;
    logic [DATA_W:0]     shl_full_c, shr_full_c;
    logic [10:0]         sh_amt_c;
    logic [31:0]         rot_amt_c;
    logic                unused_c;

    assign dbg_rdata = mem_q[dbg_addr];
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign err       = err_q;
    assign pc_out    = pc_q;
    assign psr_out   = psr_q;
    // High dest bits beyond the memory address range are intentionally ignored.
    assign unused_c  = ^dest_q;

    assign rs_c      = rf_q[src_q[3:0]];
    assign rd_c      = rf_q[dest_q[3:0]];
    assign imm_c     = DATA_W'(src_q);
    assign operand_c = cc_q[3] ? imm_c : rs_c;
    assign sum_c     = {1'b0, rd_c} + {1'b0, operand_c};

    // Shifter: left logical / right arithmetic, carry is the last bit shifted out.
    always_comb begin
        sh_amt_c    = src_q[10:0];
        shl_full_c  = {1'b0, rd_c} << sh_amt_c;
        shr_full_c  = $signed({rd_c, 1'b0}) >>> sh_amt_c;
        shift_res_c = rd_c;
        shift_c_c   = 1'b0;
        if (src_q[11]) begin
            if (32'(sh_amt_c) >= DATA_W) begin
                shift_res_c = '0;
            end else if (sh_amt_c != 11'd0) begin
                shift_res_c = shl_full_c[DATA_W-1:0];
                shift_c_c   = shl_full_c[DATA_W];
            end
        end else begin
            shift_res_c = shr_full_c[DATA_W:1];
            shift_c_c   = (sh_amt_c == 11'd0) ? 1'b0 : shr_full_c[0];
        end
    end

    // Rotator: control word comes from r[src], amount reduced modulo the word width.
    always_comb begin
        rot_amt_c = 32'(rs_c[10:0]) % DATA_W;
        if (rs_c[11]) begin
            rot_res_c = (rd_c << rot_amt_c) | (rd_c >> (DATA_W - rot_amt_c));
        end else begin
            rot_res_c = (rd_c >> rot_amt_c) | (rd_c << (DATA_W - rot_amt_c));
        end
    end

    always_comb begin
        case (cc_q)
            4'd0:    branch_c = 1'b1;
            4'd1:    branch_c = psr_q[1];
            4'd2:    branch_c = psr_q[2];
            4'd3:    branch_c = psr_q[0];
            4'd4:    branch_c = psr_q[3];
            4'd5:    branch_c = psr_q[4];
            4'd6:    branch_c = ~psr_q[0];
            4'd7:    branch_c = ~psr_q[3];
            default: branch_c = 1'b0;
        endcase
    end

    // Next-state, datapath and memory write control.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        opcode_d = opcode_q;
        cc_d     = cc_q;
        src_d    = src_q;
        dest_d   = dest_q;
        psr_d    = psr_q;
        err_d    = err_q;
        rf_d     = rf_q;
        result_c = '0;
        carry_c  = 1'b0;
        flags_c  = 1'b0;

        mem_we_c    = 1'b0;
        mem_waddr_c = prog_addr;
        mem_wdata_c = prog_wdata;
        if (prog_we && !busy_q) begin
            mem_we_c = 1'b1;
        end

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = MEM_AW'(START_PC);
                    err_d   = 1'b0;
                end
            end
            S_FETCH: begin
                instr_d = mem_q[pc_q][31:0];
                state_d = S_DECODE;
            end
            S_DECODE: begin
                opcode_d = instr_q[31:28];
                cc_d     = instr_q[27:24];
                src_d    = instr_q[23:12];
                dest_d   = instr_q[11:0];
                state_d  = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                pc_d    = pc_q + MEM_AW'(1);
                case (opcode_q)
                    OP_NOP: ;
                    OP_LOAD: begin
                        result_c = cc_q[3] ? imm_c : mem_q[src_q[MEM_AW-1:0]];
                        flags_c  = 1'b1;
                    end
                    OP_STORE: begin
                        psr_d   = '0;
                        state_d = S_WRITEBACK;
                    end
                    OP_BRANCH: begin
                        if (branch_c) pc_d = dest_q[MEM_AW-1:0];
                    end
                    OP_XOR: begin
                        result_c = rd_c ^ operand_c;
                        flags_c  = 1'b1;
                    end
                    OP_ADD: begin
                        result_c = sum_c[DATA_W-1:0];
                        carry_c  = sum_c[DATA_W];
                        flags_c  = 1'b1;
                    end
                    OP_ROTATE: begin
                        result_c = rot_res_c;
                        carry_c  = psr_q[0];
                        flags_c  = 1'b1;
                    end
                    OP_SHIFT: begin
                        result_c = shift_res_c;
                        carry_c  = shift_c_c;
                        flags_c  = 1'b1;
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                    end
                    OP_COMPL: begin
                        result_c = ~rs_c;
                        flags_c  = 1'b1;
                    end
                    default: begin
                        err_d   = 1'b1;
                        pc_d    = pc_q;
                        state_d = S_HALT;
                    end
                endcase
                if (flags_c) begin
                    rf_d[dest_q[3:0]] = result_c;
                    psr_d = {(result_c == '0), result_c[DATA_W-1], ~result_c[0],
                             ^result_c, carry_c};
                end
            end
            S_WRITEBACK: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = dest_q[MEM_AW-1:0];
                mem_wdata_c = rs_c;
                state_d     = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        if (rst) mem_we_c = 1'b0;

        busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) ||
                   (state_d == S_EXECUTE) || (state_d == S_WRITEBACK);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= MEM_AW'(START_PC);
            instr_q  <= '0;
            opcode_q <= '0;
            cc_q     <= '0;
            src_q    <= '0;
            dest_q   <= '0;
            psr_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            opcode_q <= opcode_d;
            cc_q     <= cc_d;
            src_q    <= src_d;
            dest_q   <= dest_d;
            psr_q    <= psr_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) mem_q[mem_waddr_c] <= mem_wdata_c;
    end

endmodule

// File: tb/tb_param_processor.sv
// Directed self-checking bench for param_processor: small hand-assembled programs
// with expected memory, flag and control values worked out by hand.
module tb_param_processor;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MEM_AW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              prog_we;
    logic [MEM_AW-1:0] prog_addr;
    logic [DATA_W-1:0] prog_wdata;
    logic [MEM_AW-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_rdata;
    logic              busy;
    logic              halted;
    logic              err;
    logic [MEM_AW-1:0] pc_out;
    logic [4:0]        psr_out;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] I_HALT = 32'h8000_0000;

    param_processor #(.DATA_W(DATA_W), .MEM_AW(MEM_AW), .START_PC(2)) dut (
        .clk(clk), .rst(rst), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_wdata(prog_wdata), .dbg_addr(dbg_addr),
        .dbg_rdata(dbg_rdata), .busy(busy), .halted(halted), .err(err),
        .pc_out(pc_out), .psr_out(psr_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_wdata = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [7:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        check(tag, dbg_rdata, exp);
    endtask

    task automatic run_prog(input string tag);
        int n;
        n = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (halted !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(halted), 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; prog_we = 1'b0;
        prog_addr = '0; prog_wdata = '0; dbg_addr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_pc", 32'(pc_out), 32'd2);
        check("rst_psr", 32'(psr_out), 32'd0);

        // Popcount of mem[0] into mem[1]
        poke(0, 32'd6);           poke(1, 32'd0);
        poke(3, 32'h1000_0000);   poke(4, 32'h1800_0001);
        poke(5, 32'h4800_0000);   poke(6, 32'h3500_000B);
        poke(7, 32'h3200_0009);   poke(8, 32'h5800_1001);
        poke(9, 32'h7000_1000);   poke(10, 32'h3000_0005);
        poke(11, 32'h2000_1001);  poke(12, I_HALT);
        poke(2, 32'h0000_0000);
        run_prog("pop_halt");
        peek("pop_result", 1, 32'd2);
        check("pop_err", 32'(err), 32'd0);

        // ADD carry out
        poke(0, 32'hFFFF_FFFF);
        poke(2, 32'h1000_0000); poke(3, 32'h5800_1000); poke(4, I_HALT);
        run_prog("add_halt");
        check("add_psr", 32'(psr_out), 32'b10101);
        poke(5, 32'h0000_1234);
        poke(2, 32'h2000_0005); poke(3, I_HALT);
        run_prog("add_store_halt");
        peek("add_r0", 5, 32'h0);
        check("store_psr", 32'(psr_out), 32'd0);

        // Shifts
        poke(0, 32'h8000_0000);
        poke(2, 32'h1000_0000); poke(3, 32'h7000_4000); poke(4, I_HALT);
        run_prog("shr_halt");
        check("shr4_psr", 32'(psr_out), 32'b01110);
        poke(2, 32'h2000_0006); poke(3, 32'h1000_0000);
        poke(4, 32'h7080_1000); poke(5, I_HALT);
        run_prog("shl_halt");
        peek("shr4_val", 6, 32'hF800_0000);
        check("shl1_psr", 32'(psr_out), 32'b10101);
        poke(2, 32'h1000_0000); poke(3, 32'h7002_8000); poke(4, I_HALT);
        run_prog("shr40_halt");
        check("shr40_psr", 32'(psr_out), 32'b01001);

        // Rotate by register control, then complement
        poke(0, 32'h8000_0001);
        poke(2, 32'h1880_4001); poke(3, 32'h1000_0000);
        poke(4, 32'h6000_1000); poke(5, 32'h2000_0014);
        poke(6, 32'h9000_0002); poke(7, I_HALT);
        run_prog("rot_halt");
        peek("rotl4_val", 20, 32'h0000_0018);
        check("compl_psr", 32'(psr_out), 32'b01000);

        // Illegal opcode
        poke(2, 32'hA000_0000);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        check("ill_not_yet", 32'(halted), 32'd0);
        @(negedge clk);
        check("ill_halted", 32'(halted), 32'd1);
        check("ill_err", 32'(err), 32'd1);
        check("ill_pc", 32'(pc_out), 32'd2);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("restart_err", 32'(err), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        check("ill_again", 32'(err), 32'd1);

        // Write and start on the same edge: FETCH sees the new word
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 8'd2; prog_wdata = I_HALT; start = 1'b1;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        check("wstart_halted", 32'(halted), 32'd1);
        check("wstart_err", 32'(err), 32'd0);

        // Reset during STORE writeback
        poke(8, 32'hDEAD_BEEF);
        poke(2, 32'h2000_0008); poke(3, I_HALT);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        check("wb_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pc", 32'(pc_out), 32'd2);
        peek("abort_mem", 8, 32'hDEAD_BEEF);
        run_prog("post_rst_halt");
        peek("regs_cleared", 8, 32'h0);

        // Latency: NOP then HALT, plus a write attempt while busy
        poke(10, 32'h11);
        poke(2, 32'h0000_0000); poke(3, I_HALT);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        prog_we = 1'b1; prog_addr = 8'd10; prog_wdata = 32'h55;
        check("lat_busy", 32'(busy), 32'd1);
        @(negedge clk); prog_we = 1'b0;
        repeat (4) @(negedge clk);
        check("lat_c5", 32'(halted), 32'd0);
        @(negedge clk);
        check("lat_c6", 32'(halted), 32'd1);
        peek("busy_we_ignored", 10, 32'h11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
